// File: rtl/rs_error_corrector.sv
// rs_error_corrector: final RS(544,514) decoder stage. Collects the error list
// for one codeword from the Forney unit, then streams the buffered received
// symbols out of the FIFO with each error magnitude XORed into its symbol.
//
// state   | meaning
// LOAD    | accepting (pos, mag) error beats into the table until err_last
// CORRECT | pulling symbols from the FIFO, correcting and emitting them
module rs_error_corrector #(
  parameter int N        = 544,
  parameter int K        = 514,
  parameter int T        = 15,
  parameter int SYM_W    = 10,
  parameter int POS_W    = 10,
  parameter int MSG_ONLY = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SYM_W-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_pull,
  input  logic             err_valid,
  output logic             err_ready,
  input  logic [POS_W-1:0] err_pos,
  input  logic [SYM_W-1:0] err_mag,
  input  logic             err_nul,
  input  logic             err_last,
  input  logic             err_fail,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_fail
);

  typedef enum logic {LOAD, CORRECT} state_t;

  localparam int CNT_W = $clog2(T + 1);
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(N - 1);
  localparam logic [POS_W-1:0] EOP_IDX  = (MSG_ONLY != 0) ? POS_W'(K - 1) : POS_W'(N - 1);
  localparam logic [POS_W-1:0] K_IDX    = POS_W'(K);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [POS_W-1:0]   sym_idx;
  logic               fail;
  logic [POS_W-1:0]   tbl_pos [T];
  logic [SYM_W-1:0]   tbl_mag [T];
  logic [SYM_W-1:0]   corr_mag;

  logic err_acc, sym_acc, entry_wr, table_full, pos_bad, emit;

  // Handshakes are gated by reset; fifo_pull deliberately ignores fifo_empty
  // because the FIFO's bypass path makes empty depend on pull.
  assign err_ready  = rst_ni & (state == LOAD);
  assign fifo_pull  = rst_ni & (state == CORRECT) & (~out_valid | out_ready);
  assign err_acc    = err_valid & err_ready;
  assign sym_acc    = fifo_pull & ~fifo_empty;
  assign table_full = err_acc & ~err_nul & (count == CNT_W'(T));
  assign entry_wr   = err_acc & ~err_nul & ~table_full;
  assign pos_bad    = err_acc & ~err_nul & ({1'b0, err_pos} >= (POS_W + 1)'(N));
  assign emit       = (MSG_ONLY == 0) || (sym_idx < K_IDX);

  // Sum of all table magnitudes whose position matches the current symbol.
  always_comb begin
    corr_mag = '0;
    for (int i = 0; i < T; i++) begin
      if ((CNT_W'(i) < count) && (tbl_pos[i] == sym_idx)) begin
        corr_mag = corr_mag ^ tbl_mag[i];
      end
    end
  end

  // Error table storage; entries beyond count are ignored, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (entry_wr) begin
      tbl_pos[count] <= err_pos;
      tbl_mag[count] <= err_mag;
    end
  end

  // Sequencer, symbol counter and registered output stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= LOAD;
      count     <= '0;
      sym_idx   <= '0;
      fail      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_fail  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (err_acc) begin
            if (entry_wr) count <= count + 1'b1;
            fail <= fail | table_full | pos_bad | (err_last & err_fail);
            if (err_last) state <= CORRECT;
          end
        end
        CORRECT: begin
          if (sym_acc) begin
            if (sym_idx == LAST_IDX) begin
              sym_idx <= '0;
              count   <= '0;
              fail    <= 1'b0;
              state   <= LOAD;
            end else begin
              sym_idx <= sym_idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase

      if (sym_acc && emit) begin
        out_valid <= 1'b1;
        out_data  <= fail ? fifo_data : (fifo_data ^ corr_mag);
        out_sop   <= (sym_idx == '0);
        out_eop   <= (sym_idx == EOP_IDX);
        out_fail  <= fail;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_error_corrector.sv
// tb_rs_error_corrector: codeword-level bench with a FIFO model, a random
// sink and an expected-symbol scoreboard.
module tb_rs_error_corrector;

  localparam int N = 544;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [9:0] fifo_data = '0;
  logic       fifo_empty = 1'b1;
  logic       fifo_pull;
  logic       err_valid = 1'b0;
  logic       err_ready;
  logic [9:0] err_pos = '0;
  logic [9:0] err_mag = '0;
  logic       err_nul = 1'b0;
  logic       err_last = 1'b0;
  logic       err_fail = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_data;
  logic       out_sop, out_eop, out_fail;

  rs_error_corrector dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
    .err_valid(err_valid), .err_ready(err_ready), .err_pos(err_pos),
    .err_mag(err_mag), .err_nul(err_nul), .err_last(err_last), .err_fail(err_fail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_fail(out_fail)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [9:0] data;
    logic       sop;
    logic       eop;
    logic       fail;
  } exp_t;

  typedef struct packed {
    logic [9:0] pos;
    logic [9:0] mag;
    logic       nul;
    logic       last;
    logic       fail;
  } beat_t;

  typedef struct {
    int         n;
    logic [9:0] pos [4];
    logic [9:0] mag [4];
    logic       efail;
    logic       exp_fail;
    int         seed;
  } case_t;

  int         checks = 0;
  int         failures = 0;
  int         pull_viol = 0;
  int         acc_cnt = 0;
  bit         rnd = 0;
  bit         pend_acc = 0;
  logic [9:0] sym_q [$];
  exp_t       exp_q [$];
  beat_t      beat_q [$];
  logic [9:0] corr [N];
  logic [9:0] popped;
  exp_t       e_pop;
  case_t      cases [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model and sink: drive at negedge, decide handshakes just after.
  initial begin
    forever begin
      @(negedge clk_i);
      if (pend_acc) begin
        popped = sym_q.pop_front();
        acc_cnt++;
      end
      out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_empty = (sym_q.size() == 0) || (rnd && ($urandom_range(0, 3) == 0));
      fifo_data  = (sym_q.size() != 0) ? sym_q[0] : 10'd0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          e_pop = exp_q.pop_front();
          chk("sym", 32'({out_data, out_sop, out_eop, out_fail}), 32'(e_pop));
        end
      end
      if (fifo_pull && err_ready) pull_viol++;
      pend_acc = fifo_pull && !fifo_empty;
    end
  end

  task automatic clear_cw();
    beat_q.delete();
    for (int i = 0; i < N; i++) corr[i] = '0;
  endtask

  task automatic add_beat(input logic [9:0] pos, input logic [9:0] mag, input logic nul);
    beat_t b;
    b = '{pos: pos, mag: mag, nul: nul, last: 1'b0, fail: 1'b0};
    beat_q.push_back(b);
    if (!nul && pos < 10'(N)) corr[pos] = corr[pos] ^ mag;
  endtask

  task automatic finish_list(input logic efail);
    beat_t b;
    b = beat_q.pop_back();
    b.last = 1'b1;
    b.fail = efail;
    beat_q.push_back(b);
  endtask

  task automatic push_syms(input int seed, input logic exp_fail);
    exp_t       e;
    logic [9:0] raw;
    for (int i = 0; i < N; i++) begin
      raw    = 10'((i + seed * 37) % 1024);
      e.data = exp_fail ? raw : (raw ^ corr[i]);
      e.sop  = (i == 0);
      e.eop  = (i == N - 1);
      e.fail = exp_fail;
      sym_q.push_back(raw);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beats();
    int k;
    foreach (beat_q[j]) begin
      @(negedge clk_i);
      err_valid = 1'b1;
      err_pos   = beat_q[j].pos;
      err_mag   = beat_q[j].mag;
      err_nul   = beat_q[j].nul;
      err_last  = beat_q[j].last;
      err_fail  = beat_q[j].fail;
      k = 0;
      #1;
      while (!err_ready && k < 20000) begin
        @(negedge clk_i);
        #1;
        k++;
      end
      if (!err_ready) begin
        chk("beat_timeout", 32'(err_ready), 32'(1));
        err_valid = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
      err_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || sym_q.size() != 0) && k < 30000) begin
      @(negedge clk_i);
      #2;
      k++;
    end
    chk("drain_left", 32'(exp_q.size() + sym_q.size()), 32'(0));
    repeat (3) @(negedge clk_i);
  endtask

  task automatic prep_case(input int ci);
    clear_cw();
    if (cases[ci].n == 0) add_beat(10'd0, 10'd0, 1'b1);
    for (int j = 0; j < cases[ci].n; j++) add_beat(cases[ci].pos[j], cases[ci].mag[j], 1'b0);
    finish_list(cases[ci].efail);
    push_syms(cases[ci].seed, cases[ci].exp_fail);
  endtask

  initial begin
    cases[0] = '{n: 0, pos: '{10'd0, 10'd0, 10'd0, 10'd0}, mag: '{10'd0, 10'd0, 10'd0, 10'd0},
                 efail: 1'b0, exp_fail: 1'b0, seed: 0};
    cases[1] = '{n: 3, pos: '{10'd0, 10'd271, 10'd543, 10'd0}, mag: '{10'h001, 10'h3FF, 10'h155, 10'd0},
                 efail: 1'b0, exp_fail: 1'b0, seed: 1};
    cases[2] = '{n: 2, pos: '{10'd5, 10'd5, 10'd0, 10'd0}, mag: '{10'h00F, 10'h0F0, 10'd0, 10'd0},
                 efail: 1'b0, exp_fail: 1'b0, seed: 2};
    cases[3] = '{n: 2, pos: '{10'd5, 10'd5, 10'd0, 10'd0}, mag: '{10'h00F, 10'h0F0, 10'd0, 10'd0},
                 efail: 1'b1, exp_fail: 1'b1, seed: 3};
    cases[4] = '{n: 1, pos: '{10'd544, 10'd0, 10'd0, 10'd0}, mag: '{10'h3FF, 10'd0, 10'd0, 10'd0},
                 efail: 1'b0, exp_fail: 1'b1, seed: 4};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_err_ready", 32'(err_ready), 32'(0));
    chk("rst_fifo_pull", 32'(fifo_pull), 32'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_err_ready", 32'(err_ready), 32'(1));
    chk("post_rst_fifo_pull", 32'(fifo_pull), 32'(0));

    // Table-driven codewords.
    for (int ci = 0; ci < 5; ci++) begin
      prep_case(ci);
      send_beats();
      drain();
    end

    // Sixteen non-nul beats overflow the 15-entry table.
    clear_cw();
    for (int j = 0; j < 16; j++) add_beat(10'(j * 3), 10'h001, 1'b0);
    finish_list(1'b0);
    push_syms(5, 1'b1);
    send_beats();
    drain();

    // Three back-to-back codewords under random backpressure and FIFO stalls.
    rnd = 1;
    for (int ci = 0; ci < 3; ci++) begin
      prep_case(ci + 1);
      send_beats();
    end
    drain();
    rnd = 0;
    repeat (3) @(negedge clk_i);
    chk("pull_in_load", 32'(pull_viol), 32'(0));

    // Reset one cycle after symbol 200 is accepted.
    begin
      int base;
      int k;
      base = acc_cnt;
      prep_case(1);
      send_beats();
      k = 0;
      forever begin
        @(negedge clk_i);
        #2;
        k++;
        if ((pend_acc && acc_cnt == base + 200) || k > 5000) break;
      end
      chk("sym200_reached", 32'(acc_cnt - base), 32'(200));
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_out_bits", 32'({out_data, out_sop, out_eop, out_fail}), 32'(0));
      chk("mid_rst_err_ready", 32'(err_ready), 32'(0));
      chk("mid_rst_fifo_pull", 32'(fifo_pull), 32'(0));
      sym_q.delete();
      exp_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("mid_rst_release_ready", 32'(err_ready), 32'(1));
      prep_case(2);
      send_beats();
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
